// File: rtl/block_sched_pkg.sv
// Shared types and constants for the round-robin block scheduler.
package block_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int NREQ_DEF    = 4;
    localparam int WIDTH_DEF   = 4;
    localparam int WAIT_DEF    = 2;
    localparam int OPS_PER_REQ = 4;

    // Bit offset of requester idx's operand group within op_flat.
    function automatic int op_lsb(input int idx, input int width);
        return idx * OPS_PER_REQ * width;
    endfunction

endpackage

// File: rtl/block_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  pick_o,
    output logic             valid_o
);

    int j;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!valid_o && req_i[j]) begin
                pick_o[j] = 1'b1;
                valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_sched.sv
// Shares one block instance among NREQ requesters: round-robin grant, fixed settle
// wait, result capture and a 4-phase req/ack return path.
module block_sched
    import block_sched_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int WAIT_CYCLES = WAIT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*4*WIDTH-1:0]     op_flat,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             ack,
    output logic [WIDTH-1:0]            res,
    output logic                        busy,
    output logic [WIDTH-1:0]            blk_in1,
    output logic [WIDTH-1:0]            blk_in2,
    output logic [WIDTH-1:0]            blk_in3,
    output logic [WIDTH-1:0]            blk_in4,
    input  logic [WIDTH-1:0]            blk_out
);

    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W   = $clog2(WAIT_CYCLES + 1);
    localparam int SLICE_W = OPS_PER_REQ * WIDTH;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    ack_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   blk_in1_q;
    logic [WIDTH-1:0]   blk_in2_q;
    logic [WIDTH-1:0]   blk_in3_q;
    logic [WIDTH-1:0]   blk_in4_q;

    logic [NREQ-1:0]    pick_d;
    logic               pick_vld_d;
    logic [PTR_W-1:0]   pick_idx_d;
    logic [SLICE_W-1:0] slice_d;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_d),
        .valid_o (pick_vld_d)
    );

    // The picker is one-hot, so the last match is the only match.
    always_comb begin
        pick_idx_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_d[i]) begin
                pick_idx_d = PTR_W'(i);
            end
        end
        slice_d = op_flat[op_lsb(int'(pick_idx_d), WIDTH) +: SLICE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NREQ - 1);
            gidx_q    <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            res_q     <= '0;
            blk_in1_q <= '0;
            blk_in2_q <= '0;
            blk_in3_q <= '0;
            blk_in4_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        gnt_q     <= pick_d;
                        gidx_q    <= pick_idx_d;
                        blk_in1_q <= slice_d[0*WIDTH +: WIDTH];
                        blk_in2_q <= slice_d[1*WIDTH +: WIDTH];
                        blk_in3_q <= slice_d[2*WIDTH +: WIDTH];
                        blk_in4_q <= slice_d[3*WIDTH +: WIDTH];
                        cnt_q     <= CNT_W'(WAIT_CYCLES);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    // Requests (including withdrawal of the granted one) are ignored here.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_q   <= blk_out;
                        ack_q   <= gnt_q;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!req[gidx_q]) begin
                        gnt_q   <= '0;
                        ack_q   <= '0;
                        ptr_q   <= gidx_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign res     = res_q;
    assign busy    = (state_q != IDLE);
    assign blk_in1 = blk_in1_q;
    assign blk_in2 = blk_in2_q;
    assign blk_in3 = blk_in3_q;
    assign blk_in4 = blk_in4_q;

endmodule
